mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Sequences the processor's single shared memory port between the instruction-fetch requester and the load/store (data) requester.
- Data accesses win by default. A streak counter guarantees fetch progress, and a watchdog aborts accesses the memory never acknowledges.
- Sits inside main, between the fetch/LSU stages and the unified memory model.

Parameters:
AW, 32, address width
DW, 32, data width; DW/8 byte strobes
MAX_DSTREAK, 4, max consecutive data grants while fetch is waiting
TIMEOUT, 16, cycles in a BUSY state without mem_ready before abort

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held with if_addr until if_done
if_addr  in  AW  fetch address
if_rdata  out  DW  fetched word, valid while if_done=1
if_done  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request; held with d_* inputs until d_done
d_we  in  1  1=store, 0=load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_wstrb  in  DW/8  store byte enables
d_rdata  out  DW  load data, valid while d_done=1
d_done  out  1  one-cycle completion pulse for data
err  out  1  high with a done pulse when the access timed out
mem_req  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_wstrb  out  DW/8  memory byte enables
mem_rdata  in  DW  memory read data, valid with mem_ready
mem_ready  in  1  memory completes the access on this cycle

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RESP. All outputs are registered.
- Reset (async, any state):
  - state=IDLE; mem_req=0, mem_we=0, mem_addr/wdata/wstrb=0.
  - if_done=0, d_done=0, err=0, if_rdata=0, d_rdata=0.
  - Streak and timeout counters = 0.
  - An in-flight access is dropped silently; no done pulse is generated.
- IDLE arbitration:
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both requests and streak<MAX_DSTREAK: grant data, streak++.
  - Both requests and streak==MAX_DSTREAK: grant fetch.
  - Any fetch grant clears streak. A data grant with if_req=0 also clears streak.
- Grant (edge leaving IDLE):
  - Latch the winner's address/data/we/wstrb onto the mem_* outputs and set mem_req=1.
  - Fetch grants force mem_we=0 and mem_wstrb=0.
  - Next state is BUSY_I or BUSY_D; timeout counter cleared.
- BUSY_x:
  - mem_req and the mem_* fields stay stable until mem_ready=1 is sampled.
  - On mem_ready=1 at an edge: capture mem_rdata into x_rdata, drop mem_req, x_done=1, err=0, go to RESP.
  - Stores still pulse d_done; d_rdata is loaded with mem_rdata and its value is don't-care.
- Timeout:
  - If the counter reaches TIMEOUT-1 with mem_ready=0: drop mem_req, x_done=1, err=1, x_rdata=0, go to RESP.
  - A mem_ready arriving on that same cycle wins: normal completion, err=0.
- RESP:
  - done/err are high for exactly this one cycle.
  - Requests are ignored in RESP, so a still-asserted completed req is never re-granted.
  - Go to IDLE next cycle. The requester drops req or presents its next request in this cycle.
- Latency:
  - req at cycle 0 → mem_req at cycle 1.
  - mem_ready at cycle k≥1 → done at cycle k+1.
  - Idle→idle minimum: 3 cycles per access.
- Exclusivity: if_done and d_done are never high together, and mem_req never toggles mid-access.
- Requesters must not change the address or data while req=1 before done. Behaviour under such a change is undefined.

Test Plan:
- Single fetch: if_req, if_addr=0x100; memory returns 0x00500093 with mem_ready at cycle 1 → mem_req cycle 1, mem_addr=0x100, mem_we=0, if_done with if_rdata=0x00500093 at cycle 2, err=0.
- Store: d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=0x3, mem_ready after 3 wait cycles → mem_* held stable for 4 cycles, d_done once, if_done never asserted.
- Contention and starvation: if_req and d_req held high continuously, with mem_ready always 1 → grant order D,D,D,D,I,D,D,D,D,I (MAX_DSTREAK=4).
- Timeout: d_req with mem_ready stuck at 0 → mem_req drops after 16 cycles, then d_done=1, err=1, d_rdata=0. A following fetch then completes normally with err=0.
- Reset mid-access: assert reset while in BUSY_D, asynchronously between edges → mem_req=0 immediately, no d_done pulse. After release, a new if_req completes normally.
- Held request: requester keeps if_req high through RESP → exactly one if_done per access; the next grant starts in the IDLE cycle after RESP.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW/8-1:0] d_wstrb;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ready,
    output if_rdata, if_done, d_rdata, d_done, err, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ready,
    input  if_rdata, if_done, d_rdata, d_done, err, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, data-priority with fetch anti-starvation and a watchdog
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 16
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW/8-1:0] mem_wstrb_q, mem_wstrb_d;
  logic if_done_q, if_done_d, d_done_q, d_done_d, err_q, err_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d, rd;
  logic gnt_d, gnt_i, fin;
  assign gnt_d = bus.d_req && !(bus.if_req && streak_q == SW'(MAX_DSTREAK));
  assign gnt_i = bus.if_req && !gnt_d;
  // a ready on the final watchdog cycle still counts as a normal completion
  assign fin   = bus.mem_ready || tmo_q == TW'(TIMEOUT - 1);
  assign rd    = bus.mem_ready ? bus.mem_rdata : '0;
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: if (gnt_d || gnt_i) begin
        state_d     = gnt_d ? BUSY_D : BUSY_I;
        streak_d    = (gnt_d && bus.if_req) ? streak_q + 1'b1 : '0;
        tmo_d       = '0;
        mem_req_d   = 1'b1;
        mem_we_d    = gnt_d && bus.d_we;
        mem_addr_d  = gnt_d ? bus.d_addr : bus.if_addr;
        mem_wdata_d = gnt_d ? bus.d_wdata : '0;
        mem_wstrb_d = gnt_d ? bus.d_wstrb : '0;
      end
      BUSY_I, BUSY_D: if (fin) begin
        state_d    = RESP;
        mem_req_d  = 1'b0;
        err_d      = !bus.mem_ready;
        if_done_d  = state_q == BUSY_I;
        d_done_d   = state_q == BUSY_D;
        if_rdata_d = state_q == BUSY_I ? rd : if_rdata_q;
        d_rdata_d  = state_q == BUSY_D ? rd : d_rdata_q;
      end else
        tmo_d = tmo_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.err       = err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
endmodule
